fft_sample_store: RTL and testbench

Sample/result buffer between the AXI bridge and the FFT core. Accepts samples written by the bridge's RAM interface and, on data-loaded, streams them to the FFT core in bit-reversed order with valid/ready. It then collects FFT results, raises calc-end, and serves the bridge's result reads.

---
 rtl/fft_sample_store.sv | 168 ++++++++++++++++
 tb/tb_fft_sample_store.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_store.sv
// Sample/result buffer between the AXI bridge RAM port and the FFT core.
// Loads samples, streams them bit-reversed with valid/ready, collects results, serves readback.
module fft_sample_store #(
  parameter int FFT_LOG2N    = 12,
  parameter int SAMPLE_WIDTH = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_WRITE_ram,
  input  logic                    i_READ_ram,
  input  logic [11:0]             i_SAMPLE_INDEX_ram,
  input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE_ram,
  input  logic                    i_DATA_LOADED,
  output logic [RESULT_WIDTH-1:0] o_DATA_FROM_RAM,
  output logic                    o_CALC_END,
  output logic [11:0]             o_SAMPLES_NUMBER,
  output logic [SAMPLE_WIDTH-1:0] o_fft_sample,
  output logic                    o_fft_valid,
  output logic                    o_fft_last,
  input  logic                    i_fft_ready,
  input  logic [RESULT_WIDTH-1:0] i_res_data,
  input  logic                    i_res_valid,
  input  logic                    i_res_last,
  output logic                    o_res_ready
);
  localparam int N  = 1 << FFT_LOG2N;
  localparam int CW = FFT_LOG2N + 1;

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_COLLECT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, k_q, k_d;
  logic [FFT_LOG2N-1:0]    res_idx_q, res_idx_d;
  logic                    s1_vld_q, s1_vld_d, s1_zero_q, s1_zero_d, s1_last_q, s1_last_d;
  logic                    out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [SAMPLE_WIDTH-1:0] out_sample_q, out_sample_d;
  logic [RESULT_WIDTH-1:0] rdata_q, rdata_d;

  logic [SAMPLE_WIDTH-1:0] sample_mem [N];
  logic [RESULT_WIDTH-1:0] result_mem [N];
  logic [SAMPLE_WIDTH-1:0] s1_data_q;

  logic                 idx_ok, wr_ok, load_out, issue, fire, res_we;
  logic [FFT_LOG2N-1:0] idx_lo, rd_addr;
  logic [CW-1:0]        idx_p1;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] x);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) r[i] = x[FFT_LOG2N-1-i];
    return r;
  endfunction

  always_comb begin
    idx_ok   = {1'b0, i_SAMPLE_INDEX_ram} < 13'(N);
    idx_lo   = i_SAMPLE_INDEX_ram[FFT_LOG2N-1:0];
    idx_p1   = {1'b0, idx_lo} + CW'(1);
    wr_ok    = i_WRITE_ram && idx_ok && (state_q == S_LOAD || state_q == S_DONE);
    // Two-stage read pipeline: stage 1 is the RAM read register, stage 2 the output register.
    load_out = s1_vld_q && (!out_vld_q || i_fft_ready);
    issue    = (state_q == S_STREAM) && (k_q != CW'(N)) && (!s1_vld_q || load_out);
    fire     = out_vld_q && i_fft_ready;
    rd_addr  = bitrev(k_q[FFT_LOG2N-1:0]);
    res_we   = (state_q == S_COLLECT) && i_res_valid;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    res_idx_d    = res_idx_q;
    s1_vld_d     = s1_vld_q;
    s1_zero_d    = s1_zero_q;
    s1_last_d    = s1_last_q;
    out_vld_d    = out_vld_q;
    out_last_d   = out_last_q;
    out_sample_d = out_sample_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_LOAD: begin
        if (wr_ok && idx_p1 > cnt_q) cnt_d = idx_p1;
        if (i_DATA_LOADED && cnt_q != '0) begin
          state_d = S_STREAM;
          k_d     = '0;
        end
      end
      S_STREAM: begin
        if (issue) begin
          k_d       = k_q + CW'(1);
          s1_vld_d  = 1'b1;
          s1_zero_d = {1'b0, rd_addr} >= cnt_q;
          s1_last_d = k_q == CW'(N - 1);
        end else if (load_out) begin
          s1_vld_d = 1'b0;
        end
        if (load_out) begin
          out_vld_d    = 1'b1;
          out_sample_d = s1_zero_q ? '0 : s1_data_q;
          out_last_d   = s1_last_q;
        end else if (fire) begin
          out_vld_d = 1'b0;
        end
        if (fire && out_last_q) begin
          state_d    = S_COLLECT;
          res_idx_d  = '0;
          out_vld_d  = 1'b0;
          out_last_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (i_res_valid) begin
          res_idx_d = res_idx_q + 1'b1;
          if (i_res_last || res_idx_q == '1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A write restarts loading and becomes the first sample; it wins over a read.
        if (i_WRITE_ram) begin
          state_d = S_LOAD;
          cnt_d   = idx_ok ? idx_p1 : '0;
        end else if (i_READ_ram) begin
          rdata_d = idx_ok ? result_mem[idx_lo] : '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      k_q          <= '0;
      res_idx_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_last_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_sample_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      res_idx_q    <= res_idx_d;
      s1_vld_q     <= s1_vld_d;
      s1_zero_q    <= s1_zero_d;
      s1_last_q    <= s1_last_d;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      out_sample_q <= out_sample_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge i_clk) if (wr_ok) sample_mem[idx_lo] <= i_SAMPLE_ram;
  always_ff @(posedge i_clk) if (issue) s1_data_q <= sample_mem[rd_addr];
  always_ff @(posedge i_clk) if (res_we) result_mem[res_idx_q] <= i_res_data;

  assign o_DATA_FROM_RAM  = rdata_q;
  assign o_CALC_END       = state_q == S_DONE;
  assign o_SAMPLES_NUMBER = 12'(cnt_q);
  assign o_fft_sample     = out_sample_q;
  assign o_fft_valid      = out_vld_q;
  assign o_fft_last       = out_last_q;
  assign o_res_ready      = state_q == S_COLLECT;
endmodule

// File: tb/tb_fft_sample_store.sv
// Directed + randomized bench for fft_sample_store (N=8) against a behavioural model
// of the load / bit-reversed stream / collect / readback flow.
module tb_fft_sample_store;
  localparam int L = 3, N = 8, SW = 16, RW = 32;

  logic          clk = 1'b0, rst;
  logic          wr, rd, loaded, fft_ready, res_valid, res_last;
  logic [11:0]   idx;
  logic [SW-1:0] sdata;
  logic [RW-1:0] res_data;
  logic [RW-1:0] data_from_ram;
  logic          calc_end, fft_valid, fft_last, res_ready;
  logic [11:0]   samples_number;
  logic [SW-1:0] fft_sample;

  fft_sample_store #(.FFT_LOG2N(L), .SAMPLE_WIDTH(SW), .RESULT_WIDTH(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_WRITE_ram(wr), .i_READ_ram(rd),
    .i_SAMPLE_INDEX_ram(idx), .i_SAMPLE_ram(sdata), .i_DATA_LOADED(loaded),
    .o_DATA_FROM_RAM(data_from_ram), .o_CALC_END(calc_end), .o_SAMPLES_NUMBER(samples_number),
    .o_fft_sample(fft_sample), .o_fft_valid(fft_valid), .o_fft_last(fft_last),
    .i_fft_ready(fft_ready), .i_res_data(res_data), .i_res_valid(res_valid),
    .i_res_last(res_last), .o_res_ready(res_ready));

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  // model: 0 = loading, 1 = streaming/collecting, 2 = done
  int            m_state = 0, m_count = 0, m_idx = 0;
  logic [SW-1:0] smodel [N];
  logic [RW-1:0] rmodel [N];
  logic [RW-1:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < L; i++) if ((k >> i) & 1) r += 1 << (L - 1 - i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_sample(input int i, input int d);
    wr = 1'b1; idx = 12'(i); sdata = SW'(d);
    tick();
    wr = 1'b0;
    if (m_state == 0) begin
      if (i < N) begin
        smodel[i] = SW'(d);
        if (i + 1 > m_count) m_count = i + 1;
      end
    end else if (m_state == 2) begin
      m_state = 0;
      m_count = 0;
      if (i < N) begin smodel[i] = SW'(d); m_count = i + 1; end
    end
  endtask

  task automatic load_pulse();
    loaded = 1'b1;
    tick();
    loaded = 1'b0;
    if (m_state == 0 && m_count > 0) m_state = 1;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic stream(input int mode, input int stop_at);
    int got = 0, cyc = 0, first_v = -1, e;
    logic stalled = 1'b0, r, v, l;
    logic [SW-1:0] s, ps = '0;
    logic pl = 1'b0;
    while (got < stop_at && cyc < 200) begin
      if (stalled) begin
        chk("stall_valid", fft_valid, 1);
        chk("stall_sample", fft_sample, ps);
        chk("stall_last", fft_last, pl);
      end
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      fft_ready = r;
      v = fft_valid; s = fft_sample; l = fft_last;
      if (v && first_v < 0) first_v = cyc;
      tick();
      cyc++;
      if (v && r) begin
        e = bitrev(got);
        chk($sformatf("sample[%0d]", got), s, (e < m_count) ? smodel[e] : SW'(0));
        chk($sformatf("last[%0d]", got), l, got == N - 1);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = v;
      end
      ps = s; pl = l;
    end
    fft_ready = 1'b0;
    chk("stream_count", got, stop_at);
    chk("first_valid_latency_ok", (first_v >= 0 && first_v <= 2), 1);
    if (stop_at == N) begin
      chk("valid_after_last", fft_valid, 0);
      chk("res_ready_collect", res_ready, 1);
      m_idx = 0;
    end
  endtask

  task automatic collect(input int n, input int last_at, input bit rnd, input int base);
    logic [RW-1:0] d;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 2)) begin res_valid = 1'b0; tick(); end
      d = rnd ? RW'($urandom) : RW'(base + j);
      res_valid = 1'b1; res_data = d; res_last = (j == last_at);
      chk($sformatf("res_ready[%0d]", j), res_ready, m_state == 1);
      tick();
      if (m_state == 1) begin
        rmodel[m_idx] = d;
        if (j == last_at || m_idx == N - 1) m_state = 2;
        m_idx++;
      end
    end
    res_valid = 1'b0; res_last = 1'b0;
    chk("calc_end", calc_end, m_state == 2);
    chk("res_ready_done", res_ready, 0);
  endtask

  task automatic rd_result(input int i);
    rd = 1'b1; idx = 12'(i);
    tick();
    rd = 1'b0;
    m_rdata = (i < N) ? rmodel[i] : RW'(0);
    chk($sformatf("read[%0d]", i), data_from_ram, m_rdata);
  endtask

  initial begin
    rst = 1'b1; wr = 0; rd = 0; loaded = 0; fft_ready = 0; res_valid = 0; res_last = 0;
    idx = '0; sdata = '0; res_data = '0;
    tick(); tick();
    chk("rst_data", data_from_ram, 0);
    chk("rst_calc_end", calc_end, 0);
    chk("rst_samples", samples_number, 0);
    chk("rst_fft_sample", fft_sample, 0);
    chk("rst_fft_valid", fft_valid, 0);
    chk("rst_fft_last", fft_last, 0);
    chk("rst_res_ready", res_ready, 0);
    rst = 1'b0;
    tick();

    // load pulse with nothing written is ignored
    load_pulse();
    tick(); tick(); tick();
    chk("empty_load_valid", fft_valid, 0);
    chk("empty_load_count", samples_number, 0);

    // full load, in-order stream
    for (int i = 0; i < N; i++) wr_sample(i, 10 + i);
    wr_sample(9, 55);
    chk("count_full", samples_number, m_count);
    load_pulse();
    stream(0, N);
    chk("count_after_stream", samples_number, 8);

    // collect with gaps, last on 107, readback
    collect(N, N - 1, 1'b0, 100);
    for (int i = 0; i < N; i++) rd_result(i);
    rd_result(9);
    rd_result(5);
    tick(); tick();
    chk("read_hold", data_from_ram, m_rdata);

    // write in done restarts load; partial load with backpressure
    wr_sample(2, 3);
    chk("done_write_calc_end", calc_end, 0);
    chk("done_write_count", samples_number, 3);
    wr_sample(0, 1); wr_sample(1, 2); wr_sample(3, 4); wr_sample(4, 5);
    chk("count_partial", samples_number, 5);
    load_pulse();
    stream(1, N);

    // early last after 4 results; the 5th is dropped
    collect(5, 3, 1'b1, 0);
    for (int i = 0; i < N; i++) rd_result(i);

    // simultaneous read and write: write wins
    rd = 1'b1;
    wr_sample(1, 77);
    rd = 1'b0;
    chk("rw_data_hold", data_from_ram, m_rdata);
    chk("rw_calc_end", calc_end, 0);
    chk("rw_count", samples_number, m_count);

    // random load, reset mid-stream
    repeat (6) wr_sample($urandom_range(0, 9), $urandom);
    chk("count_rand", samples_number, m_count);
    load_pulse();
    stream(0, 3);
    rst = 1'b1;
    #1;
    chk("midrst_valid", fft_valid, 0);
    chk("midrst_last", fft_last, 0);
    chk("midrst_sample", fft_sample, 0);
    chk("midrst_count", samples_number, 0);
    chk("midrst_res_ready", res_ready, 0);
    tick();
    rst = 1'b0;
    m_state = 0; m_count = 0;
    tick();

    // fresh random load/stream/collect ending on index N-1 without last
    wr_sample($urandom_range(0, N - 1), $urandom);
    repeat (5) wr_sample($urandom_range(0, 9), $urandom);
    chk("count_rand2", samples_number, m_count);
    load_pulse();
    stream(2, N);
    collect(N, -1, 1'b1, 0);
    repeat (8) rd_result($urandom_range(0, 9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
